// File: rtl/hammer_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hammer_bridge_pkg
//  Purpose  : Shared types and constants for the hammer Avalon-MM bridge.
//  Revision : 1.0  initial release
// ============================================================================
package hammer_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2,
        ACK       = 2'd3
    } bridge_state_t;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_type_t;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hammer_avmm_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : hammer_avmm_bridge
//  Purpose  : Turns level-held hammer read/write requests into single-beat
//             Avalon-MM transactions, one in flight at a time.
//  Revision : 1.0  initial release
// ============================================================================
module hammer_avmm_bridge
    import hammer_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int AVM_ADDR_WIDTH = 27,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      up_read,
    input  logic                      up_write,
    input  logic [ADDR_WIDTH-1:0]     up_address,
    input  logic [DATA_WIDTH-1:0]     up_writedata,
    output logic                      up_wait_request,
    output logic                      up_read_data_valid,
    output logic [DATA_WIDTH-1:0]     up_readdata,
    output logic [AVM_ADDR_WIDTH-1:0] avm_address,
    output logic                      avm_read,
    output logic                      avm_write,
    output logic [DATA_WIDTH-1:0]     avm_writedata,
    output logic [DATA_WIDTH/8-1:0]   avm_byteenable,
    output logic                      avm_burstcount,
    input  logic                      avm_waitrequest,
    input  logic [DATA_WIDTH-1:0]     avm_readdata,
    input  logic                      avm_readdatavalid,
    output logic [31:0]               rd_count,
    output logic [31:0]               wr_count,
    output logic                      err_timeout,
    output logic                      err_protocol
);

    localparam int                c_tmo_w    = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    bridge_state_t             state_q, state_d;
    req_type_t                 type_q, type_d;
    logic [AVM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
    logic                      avm_read_q, avm_read_d;
    logic                      avm_write_q, avm_write_d;
    logic                      wait_req_q, wait_req_d;
    logic                      rdv_q, rdv_d;
    logic [31:0]               rd_cnt_q, rd_cnt_d;
    logic [31:0]               wr_cnt_q, wr_cnt_d;
    logic [c_tmo_w-1:0]        tmo_q, tmo_d;
    logic                      err_tmo_q, err_tmo_d;
    logic                      err_prot_q, err_prot_d;

    // Only the low word-address bits reach the controller.
    logic unused_up_address;
    assign unused_up_address = ^up_address;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        avm_read_d  = avm_read_q;
        avm_write_d = avm_write_q;
        wait_req_d  = 1'b1;
        rdv_d       = 1'b0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        tmo_d       = tmo_q;
        err_tmo_d   = err_tmo_q;
        err_prot_d  = err_prot_q;

        if (avm_readdatavalid && (state_q != WAIT_DATA)) begin
            err_prot_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (up_write || up_read) begin
                    type_d      = up_write ? WR : RD;
                    addr_d      = up_address[AVM_ADDR_WIDTH-1:0];
                    wdata_d     = up_writedata;
                    avm_write_d = up_write;
                    avm_read_d  = ~up_write;
                    if (up_write && up_read) begin
                        err_prot_d = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (!avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (type_q == WR) begin
                        wr_cnt_d   = sat_inc(wr_cnt_q);
                        wait_req_d = 1'b0;
                        state_d    = ACK;
                    end else begin
                        rd_cnt_d = sat_inc(rd_cnt_q);
                        tmo_d    = '0;
                        state_d  = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    rdata_d    = avm_readdata;
                    wait_req_d = 1'b0;
                    rdv_d      = 1'b1;
                    state_d    = ACK;
                end else if (tmo_q == c_tmo_last) begin
                    // Abort: acknowledge anyway so the hammer FSM never stalls.
                    err_tmo_d  = 1'b1;
                    wait_req_d = 1'b0;
                    rdv_d      = 1'b1;
                    state_d    = ACK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            type_q      <= RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            avm_read_q  <= 1'b0;
            avm_write_q <= 1'b0;
            wait_req_q  <= 1'b1;
            rdv_q       <= 1'b0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            tmo_q       <= '0;
            err_tmo_q   <= 1'b0;
            err_prot_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            avm_read_q  <= avm_read_d;
            avm_write_q <= avm_write_d;
            wait_req_q  <= wait_req_d;
            rdv_q       <= rdv_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            tmo_q       <= tmo_d;
            err_tmo_q   <= err_tmo_d;
            err_prot_q  <= err_prot_d;
        end
    end

    assign up_wait_request    = wait_req_q;
    assign up_read_data_valid = rdv_q;
    assign up_readdata        = rdata_q;
    assign avm_address        = addr_q;
    assign avm_read           = avm_read_q;
    assign avm_write          = avm_write_q;
    assign avm_writedata      = wdata_q;
    assign avm_byteenable     = '1;
    assign avm_burstcount     = 1'b1;
    assign rd_count           = rd_cnt_q;
    assign wr_count           = wr_cnt_q;
    assign err_timeout        = err_tmo_q;
    assign err_protocol       = err_prot_q;

endmodule
`default_nettype wire

// File: tb/tb_hammer_avmm_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hammer_avmm_bridge
//  Purpose  : Directed self-checking bench for hammer_avmm_bridge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hammer_avmm_bridge;

    localparam int AW  = 64;
    localparam int MAW = 27;
    localparam int DW  = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           up_read = 1'b0;
    logic           up_write = 1'b0;
    logic [AW-1:0]  up_address = '0;
    logic [DW-1:0]  up_writedata = '0;
    logic           up_wait_request;
    logic           up_read_data_valid;
    logic [DW-1:0]  up_readdata;
    logic [MAW-1:0] avm_address;
    logic           avm_read;
    logic           avm_write;
    logic [DW-1:0]  avm_writedata;
    logic [DW/8-1:0] avm_byteenable;
    logic           avm_burstcount;
    logic           avm_waitrequest = 1'b0;
    logic [DW-1:0]  avm_readdata = '0;
    logic           avm_readdatavalid = 1'b0;
    logic [31:0]    rd_count;
    logic [31:0]    wr_count;
    logic           err_timeout;
    logic           err_protocol;

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model: read data returns slave_lat cycles after the first
    // post-accept cycle; slave_lat < 0 means the slave never answers.
    int          slave_lat  = 0;
    logic [63:0] slave_data = '0;
    int          cd         = 0;
    int          overlap    = 0;

    hammer_avmm_bridge #(
        .ADDR_WIDTH    (AW),
        .AVM_ADDR_WIDTH(MAW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .up_read           (up_read),
        .up_write          (up_write),
        .up_address        (up_address),
        .up_writedata      (up_writedata),
        .up_wait_request   (up_wait_request),
        .up_read_data_valid(up_read_data_valid),
        .up_readdata       (up_readdata),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_byteenable    (avm_byteenable),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .rd_count          (rd_count),
        .wr_count          (wr_count),
        .err_timeout       (err_timeout),
        .err_protocol      (err_protocol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cd > 0) cd = cd - 1;
        if (avm_read && !avm_waitrequest) begin
            if (cd != 0) overlap = overlap + 1;
            if (slave_lat >= 0) cd = slave_lat + 1;
        end
    end

    always @(negedge clk) begin
        avm_readdatavalid = (cd == 1);
        avm_readdata      = (cd == 1) ? slave_data : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle numbering: the cycle in which the request was driven is 'start'.
    task automatic wait_ack(input int budget, input int start, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = start;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (!up_wait_request) seen = 1'b1;
        end
        if (!seen) check_eq("ack_bound_expired", 64'd0, 64'd1);
    endtask

    initial begin
        int c;
        int strobes;

        // ---------------- reset values ----------------
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("rst_wait_request", up_wait_request, 1);
        check_eq("rst_rdv",          up_read_data_valid, 0);
        check_eq("rst_readdata",     up_readdata, 0);
        check_eq("rst_avm_read",     avm_read, 0);
        check_eq("rst_avm_write",    avm_write, 0);
        check_eq("rst_avm_address",  avm_address, 0);
        check_eq("rst_avm_wdata",    avm_writedata, 0);
        check_eq("rst_byteenable",   avm_byteenable, 8'hFF);
        check_eq("rst_burstcount",   avm_burstcount, 1);
        check_eq("rst_rd_count",     rd_count, 0);
        check_eq("rst_wr_count",     wr_count, 0);
        check_eq("rst_err_timeout",  err_timeout, 0);
        check_eq("rst_err_protocol", err_protocol, 0);

        // ---------------- 1: single write ----------------
        @(negedge clk);
        up_write     = 1'b1;
        up_address   = 64'h400;
        up_writedata = 64'hA5A5_A5A5_A5A5_A5A5;
        @(negedge clk);
        check_eq("t1_avm_write", avm_write, 1);
        check_eq("t1_avm_read",  avm_read, 0);
        check_eq("t1_avm_addr",  avm_address, 27'h400);
        check_eq("t1_avm_wdata", avm_writedata, 64'hA5A5_A5A5_A5A5_A5A5);
        wait_ack(10, 2, c);
        check_eq("t1_ack_cycle", c, 3);
        check_eq("t1_ack_rdv",   up_read_data_valid, 0);
        check_eq("t1_strobe_off", avm_write, 0);
        check_eq("t1_wr_count",  wr_count, 1);
        up_write = 1'b0;
        @(negedge clk);
        check_eq("t1_post_wait", up_wait_request, 1);

        // ---------------- 2: read, slave latency 5 ----------------
        slave_lat  = 5;
        slave_data = 64'h1234;
        up_read    = 1'b1;
        up_address = 64'h800;
        wait_ack(30, 1, c);
        check_eq("t2_ack_cycle", c, 9);
        check_eq("t2_rdv",       up_read_data_valid, 1);
        check_eq("t2_readdata",  up_readdata, 64'h1234);
        up_read = 1'b0;
        @(negedge clk);
        check_eq("t2_rdv_pulse",  up_read_data_valid, 0);
        check_eq("t2_held",       up_readdata, 64'h1234);
        check_eq("t2_rd_count",   rd_count, 1);

        // ---------------- 3: waitrequest stall ----------------
        slave_lat       = 1;
        slave_data      = 64'h5555;
        avm_waitrequest = 1'b1;
        up_read         = 1'b1;
        up_address      = 64'hFFFF_FFFF_0ABC_DEF0;
        strobes         = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (avm_read) begin
                strobes++;
                check_eq("t3_addr_stable", avm_address, 27'h2BC_DEF0);
                if (strobes == 4) avm_waitrequest = 1'b0;
            end
            if (!up_wait_request) break;
        end
        check_eq("t3_strobe_cycles", strobes, 4);
        check_eq("t3_ack",          up_wait_request, 0);
        check_eq("t3_readdata",     up_readdata, 64'h5555);
        check_eq("t3_rd_count",     rd_count, 2);
        check_eq("t3_no_prot_err",  err_protocol, 0);
        up_read = 1'b0;
        @(negedge clk);

        // ---------------- read+write together ----------------
        up_read      = 1'b1;
        up_write     = 1'b1;
        up_address   = 64'h10;
        up_writedata = 64'h77;
        @(negedge clk);
        check_eq("both_avm_write", avm_write, 1);
        check_eq("both_avm_read",  avm_read, 0);
        wait_ack(10, 2, c);
        check_eq("both_ack_cycle", c, 3);
        check_eq("both_err_prot",  err_protocol, 1);
        check_eq("both_wr_count",  wr_count, 2);
        check_eq("both_rd_count",  rd_count, 2);
        up_read  = 1'b0;
        up_write = 1'b0;
        @(negedge clk);

        // ---------------- 5: read timeout ----------------
        slave_lat  = -1;
        up_read    = 1'b1;
        up_address = 64'h20;
        check_eq("t5_err_tmo_before", err_timeout, 0);
        wait_ack(40, 1, c);
        check_eq("t5_ack_cycle",  c, 19);
        check_eq("t5_err_tmo",    err_timeout, 1);
        check_eq("t5_rdv",        up_read_data_valid, 1);
        check_eq("t5_data_kept",  up_readdata, 64'h5555);
        check_eq("t5_rd_count",   rd_count, 3);
        up_read = 1'b0;
        @(negedge clk);

        // ---------------- 4: 100 back-to-back reads ----------------
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_eq("t4_rst_rd_count", rd_count, 0);
        check_eq("t4_rst_err_tmo",  err_timeout, 0);
        slave_lat  = 2;
        overlap    = 0;
        up_address = 64'h0000_1000;
        slave_data = {32'hC0DE_0000, 32'd0};
        up_read    = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wait_ack(30, 1, c);
            check_eq("t4_data", up_readdata, {32'hC0DE_0000, 32'(i)});
            up_address = ((i + 1) % 2 == 0) ? 64'h0000_1000 : 64'h0010_0000;
            slave_data = {32'hC0DE_0000, 32'(i + 1)};
        end
        up_read = 1'b0;
        @(negedge clk);
        check_eq("t4_rd_count", rd_count, 100);
        check_eq("t4_overlap",  overlap, 0);

        // ---------------- 6: reset during WAIT_DATA ----------------
        slave_lat  = 5;
        slave_data = 64'hFEED;
        up_read    = 1'b1;
        up_address = 64'h30;
        repeat (4) @(negedge clk);
        check_eq("t6_in_wait", avm_read, 0);
        reset   = 1'b1;
        up_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check_eq("t6_rst_wait_req", up_wait_request, 1);
        check_eq("t6_rst_readdata", up_readdata, 0);
        check_eq("t6_rst_err_prot", err_protocol, 0);
        repeat (3) @(negedge clk);
        check_eq("t6_stray_prot",  err_protocol, 1);
        check_eq("t6_readdata",    up_readdata, 0);
        check_eq("t6_rdv",         up_read_data_valid, 0);
        check_eq("t6_idle_wait",   up_wait_request, 1);
        check_eq("t6_avm_read",    avm_read, 0);
        check_eq("t6_rd_count",    rd_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: got timeout expected completion");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
